// File: rtl/best_1ofn_pipe_if.sv
// Candidate/result bundle for the best-1-of-N selector. The master drives the
// candidates and deadtime; the slave (the selector) returns the registered winner.
interface best_1ofn_pipe_if #(
  parameter int NCH   = 7,
  parameter int CHW   = 4,
  parameter int PATW  = 7,
  parameter int KEYW  = 5,
  parameter int OFFW  = 4,
  parameter int QLTW  = 6,
  parameter int BNDW  = 5,
  parameter int CARW  = 12,
  parameter int DEADW = 4
);
  logic                     vld_in;
  logic [NCH*PATW-1:0]      pat_in;
  logic [NCH*KEYW-1:0]      key_in;
  logic [NCH*OFFW-1:0]      offs_in;
  logic [NCH*QLTW-1:0]      qlt_in;
  logic [NCH*BNDW-1:0]      bend_in;
  logic [NCH*CARW-1:0]      carry_in;
  logic [NCH-1:0]           bsy_in;
  logic [DEADW-1:0]         deadtime;

  logic                     best_vld;
  logic                     best_bsy;
  logic [CHW-1:0]           best_ch;
  logic [PATW-1:0]          best_pat;
  logic [CHW+KEYW-1:0]      best_key;
  logic [CHW+KEYW+1:0]      best_subkey;
  logic [QLTW-1:0]          best_qlt;
  logic [BNDW-1:0]          best_bend;
  logic [CARW-1:0]          best_carry;
  logic [NCH-1:0]           lock_mask;

  modport master (
    output vld_in, pat_in, key_in, offs_in, qlt_in, bend_in, carry_in, bsy_in, deadtime,
    input  best_vld, best_bsy, best_ch, best_pat, best_key, best_subkey,
           best_qlt, best_bend, best_carry, lock_mask
  );

  modport slave (
    input  vld_in, pat_in, key_in, offs_in, qlt_in, bend_in, carry_in, bsy_in, deadtime,
    output best_vld, best_bsy, best_ch, best_pat, best_key, best_subkey,
           best_qlt, best_bend, best_carry, lock_mask
  );
endinterface

// File: rtl/best_1ofn_pipe.sv
// Two-stage best-1-of-N CLCT pattern selector with per-channel winner lockout.
// Stage 1 registers candidates and sort keys; stage 2 picks and registers the winner.

module best_1ofn_lock_cnt #(
  parameter int DEADW = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [DEADW-1:0] deadtime,
  output logic             lock
);
  logic [DEADW-1:0] cnt_q, cnt_d;

  // A load wins over the decrement, so the winner starts from the full deadtime.
  always_comb begin
    cnt_d = cnt_q;
    if (load)               cnt_d = deadtime;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign lock = (cnt_q != '0);
endmodule

module best_1ofn_pipe #(
  parameter int NCH    = 7,
  parameter int CHW    = 4,
  parameter int PATW   = 7,
  parameter int KEYW   = 5,
  parameter int OFFW   = 4,
  parameter int QLTW   = 6,
  parameter int BNDW   = 5,
  parameter int CARW   = 12,
  parameter int PATLUT = 0,
  parameter int DEADW  = 4
) (
  input logic             clock,
  input logic             reset,
  best_1ofn_pipe_if.slave bus
);
  localparam int SKW  = (QLTW > PATW-1) ? QLTW : PATW-1;
  localparam int SUBW = CHW + KEYW + 2;

  typedef struct packed {
    logic [PATW-1:0] pat;
    logic [KEYW-1:0] key;
    logic [OFFW-1:0] offs;
    logic [QLTW-1:0] qlt;
    logic [BNDW-1:0] bend;
    logic [CARW-1:0] carry;
  } cand_t;

  logic [1:0]               vld_pipe_q, vld_pipe_d;
  cand_t [NCH-1:0]          cand_s1_q, cand_s1_d;
  logic [NCH-1:0][SKW-1:0]  sk_s1_q, sk_s1_d;
  logic [NCH-1:0]           bsy_s1_q, bsy_s1_d;

  always_comb begin : s1_comb
    vld_pipe_d = {vld_pipe_q[0], bus.vld_in};
    bsy_s1_d   = bus.bsy_in;
    cand_s1_d  = '0;
    sk_s1_d    = '0;
    for (int i = 0; i < NCH; i++) begin
      cand_s1_d[i].pat   = bus.pat_in[i*PATW +: PATW];
      cand_s1_d[i].key   = bus.key_in[i*KEYW +: KEYW];
      cand_s1_d[i].offs  = bus.offs_in[i*OFFW +: OFFW];
      cand_s1_d[i].qlt   = bus.qlt_in[i*QLTW +: QLTW];
      cand_s1_d[i].bend  = bus.bend_in[i*BNDW +: BNDW];
      cand_s1_d[i].carry = bus.carry_in[i*CARW +: CARW];
      // Pattern lsb is bend direction, so it never takes part in the ranking.
      if (PATLUT != 0) sk_s1_d[i] = SKW'(cand_s1_d[i].qlt);
      else             sk_s1_d[i] = SKW'(cand_s1_d[i].pat[PATW-1:1]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      cand_s1_q  <= '0;
      sk_s1_q    <= '0;
      bsy_s1_q   <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      cand_s1_q  <= cand_s1_d;
      sk_s1_q    <= sk_s1_d;
      bsy_s1_q   <= bsy_s1_d;
    end
  end

  logic [NCH-1:0] lock, eff_bsy, win_oh;
  logic           found;
  logic [CHW-1:0] win_ch;
  logic [SKW-1:0] win_sk;
  cand_t          win_c;

  // Strict '>' keeps the lowest index on ties; busy channels are skipped outright.
  always_comb begin : s2_select
    eff_bsy = bsy_s1_q | lock;
    found   = 1'b0;
    win_ch  = '0;
    win_sk  = '0;
    win_c   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!eff_bsy[i] && (!found || sk_s1_q[i] > win_sk)) begin
        found  = 1'b1;
        win_ch = CHW'(i);
        win_sk = sk_s1_q[i];
        win_c  = cand_s1_q[i];
      end
    end
    win_oh = '0;
    for (int i = 0; i < NCH; i++)
      win_oh[i] = vld_pipe_q[0] & found & (win_ch == CHW'(i)) & (bus.deadtime != '0);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    best_1ofn_lock_cnt #(.DEADW(DEADW)) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (win_oh[g]),
      .deadtime (bus.deadtime),
      .lock     (lock[g])
    );
  end

  logic                best_bsy_q, best_bsy_d;
  logic [CHW-1:0]      best_ch_q, best_ch_d;
  logic [PATW-1:0]     best_pat_q, best_pat_d;
  logic [CHW+KEYW-1:0] best_key_q, best_key_d;
  logic [SUBW-1:0]     best_subkey_q, best_subkey_d;
  logic [QLTW-1:0]     best_qlt_q, best_qlt_d;
  logic [BNDW-1:0]     best_bend_q, best_bend_d;
  logic [CARW-1:0]     best_carry_q, best_carry_d;

  always_comb begin : out_comb
    best_bsy_d    = 1'b0;
    best_ch_d     = '0;
    best_pat_d    = '0;
    best_key_d    = '0;
    best_subkey_d = '0;
    best_qlt_d    = '0;
    best_bend_d   = '0;
    best_carry_d  = '0;
    if (vld_pipe_q[0]) begin
      if (found) begin
        best_ch_d     = win_ch;
        best_pat_d    = win_c.pat;
        best_key_d    = {win_ch, win_c.key};
        best_subkey_d = SUBW'(win_c.offs) + {1'b0, win_ch, win_c.key, 1'b0};
        best_qlt_d    = win_c.qlt;
        best_bend_d   = win_c.bend;
        best_carry_d  = win_c.carry;
      end else begin
        best_bsy_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_bsy_q    <= 1'b0;
      best_ch_q     <= '0;
      best_pat_q    <= '0;
      best_key_q    <= '0;
      best_subkey_q <= '0;
      best_qlt_q    <= '0;
      best_bend_q   <= '0;
      best_carry_q  <= '0;
    end else begin
      best_bsy_q    <= best_bsy_d;
      best_ch_q     <= best_ch_d;
      best_pat_q    <= best_pat_d;
      best_key_q    <= best_key_d;
      best_subkey_q <= best_subkey_d;
      best_qlt_q    <= best_qlt_d;
      best_bend_q   <= best_bend_d;
      best_carry_q  <= best_carry_d;
    end
  end

  assign bus.best_vld    = vld_pipe_q[1];
  assign bus.best_bsy    = best_bsy_q;
  assign bus.best_ch     = best_ch_q;
  assign bus.best_pat    = best_pat_q;
  assign bus.best_key    = best_key_q;
  assign bus.best_subkey = best_subkey_q;
  assign bus.best_qlt    = best_qlt_q;
  assign bus.best_bend   = best_bend_q;
  assign bus.best_carry  = best_carry_q;
  assign bus.lock_mask   = lock;
endmodule

// File: tb/tb_best_1ofn_pipe.sv
// Bench for best_1ofn_pipe: a pattern-sorted and a quality-sorted instance share
// stimulus; a timestamp-based lockout model predicts every registered result.
module tb_best_1ofn_pipe;
  localparam int NCH = 7, CHW = 4, PATW = 7, KEYW = 5, OFFW = 4;
  localparam int QLTW = 6, BNDW = 5, CARW = 12, DEADW = 4;
  localparam int OUTW = 2 + CHW + PATW + (CHW+KEYW) + (CHW+KEYW+2) + QLTW + BNDW + CARW + NCH;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  best_1ofn_pipe_if #(.NCH(NCH), .CHW(CHW), .PATW(PATW), .KEYW(KEYW), .OFFW(OFFW),
    .QLTW(QLTW), .BNDW(BNDW), .CARW(CARW), .DEADW(DEADW)) if0 ();
  best_1ofn_pipe_if #(.NCH(NCH), .CHW(CHW), .PATW(PATW), .KEYW(KEYW), .OFFW(OFFW),
    .QLTW(QLTW), .BNDW(BNDW), .CARW(CARW), .DEADW(DEADW)) if1 ();

  assign if1.vld_in   = if0.vld_in;
  assign if1.pat_in   = if0.pat_in;
  assign if1.key_in   = if0.key_in;
  assign if1.offs_in  = if0.offs_in;
  assign if1.qlt_in   = if0.qlt_in;
  assign if1.bend_in  = if0.bend_in;
  assign if1.carry_in = if0.carry_in;
  assign if1.bsy_in   = if0.bsy_in;
  assign if1.deadtime = if0.deadtime;

  best_1ofn_pipe #(.NCH(NCH), .CHW(CHW), .PATW(PATW), .KEYW(KEYW), .OFFW(OFFW), .QLTW(QLTW),
    .BNDW(BNDW), .CARW(CARW), .PATLUT(0), .DEADW(DEADW)) u_dut0 (
    .clock(clock), .reset(reset), .bus(if0.slave));
  best_1ofn_pipe #(.NCH(NCH), .CHW(CHW), .PATW(PATW), .KEYW(KEYW), .OFFW(OFFW), .QLTW(QLTW),
    .BNDW(BNDW), .CARW(CARW), .PATLUT(1), .DEADW(DEADW)) u_dut1 (
    .clock(clock), .reset(reset), .bus(if1.slave));

  int n_checks = 0, n_fail = 0;

  // Stimulus currently applied
  int t_pat[NCH], t_key[NCH], t_offs[NCH], t_qlt[NCH], t_bend[NCH], t_car[NCH];
  logic [NCH-1:0] t_bsy;
  logic t_vld;
  int t_dead;

  // Reference model: last sampled set, and per-channel first edge it may win again
  int edge_n;
  logic pv;
  logic [NCH-1:0] pbsy;
  int ppat[NCH], pkey[NCH], poffs[NCH], pqlt[NCH], pbend[NCH], pcar[NCH];
  int next_ok[2][NCH];
  logic exp_vld[2], exp_bsy[2];
  int exp_ch[2], exp_pat[2], exp_key[2], exp_sub[2], exp_qlt[2], exp_bend[2], exp_car[2];
  logic [NCH-1:0] exp_lock[2];

  task automatic apply();
    if0.vld_in   = t_vld;
    if0.bsy_in   = t_bsy;
    if0.deadtime = DEADW'(t_dead);
    for (int i = 0; i < NCH; i++) begin
      if0.pat_in[i*PATW +: PATW]   = PATW'(t_pat[i]);
      if0.key_in[i*KEYW +: KEYW]   = KEYW'(t_key[i]);
      if0.offs_in[i*OFFW +: OFFW]  = OFFW'(t_offs[i]);
      if0.qlt_in[i*QLTW +: QLTW]   = QLTW'(t_qlt[i]);
      if0.bend_in[i*BNDW +: BNDW]  = BNDW'(t_bend[i]);
      if0.carry_in[i*CARW +: CARW] = CARW'(t_car[i]);
    end
  endtask

  task automatic rand_set();
    for (int i = 0; i < NCH; i++) begin
      t_pat[i]  = $urandom_range(0, 127);
      t_key[i]  = $urandom_range(0, 31);
      t_offs[i] = $urandom_range(0, 15);
      t_qlt[i]  = $urandom_range(0, 63);
      t_bend[i] = $urandom_range(0, 31);
      t_car[i]  = $urandom_range(0, 4095);
    end
  endtask

  task automatic model_reset();
    pv = 1'b0;
    pbsy = '0;
    for (int m = 0; m < 2; m++) begin
      exp_vld[m] = 1'b0; exp_bsy[m] = 1'b0; exp_ch[m] = 0; exp_pat[m] = 0; exp_key[m] = 0;
      exp_sub[m] = 0; exp_qlt[m] = 0; exp_bend[m] = 0; exp_car[m] = 0; exp_lock[m] = '0;
      for (int i = 0; i < NCH; i++) next_ok[m][i] = 0;
    end
  endtask

  // One clock edge: predict the result registered at it, then sample current stimulus.
  task automatic step();
    int w, bsc, sc;
    @(posedge clock);
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      exp_vld[m] = 1'b0; exp_bsy[m] = 1'b0; exp_ch[m] = 0; exp_pat[m] = 0; exp_key[m] = 0;
      exp_sub[m] = 0; exp_qlt[m] = 0; exp_bend[m] = 0; exp_car[m] = 0;
      if (pv) begin
        w = -1; bsc = -1;
        for (int i = 0; i < NCH; i++) begin
          sc = (m == 1) ? pqlt[i] : ppat[i] / 2;
          if (!pbsy[i] && edge_n >= next_ok[m][i] && sc > bsc) begin w = i; bsc = sc; end
        end
        exp_vld[m] = 1'b1;
        if (w < 0) exp_bsy[m] = 1'b1;
        else begin
          exp_ch[m]   = w;
          exp_pat[m]  = ppat[w];
          exp_key[m]  = w * (1 << KEYW) + pkey[w];
          exp_sub[m]  = poffs[w] + 2 * exp_key[m];
          exp_qlt[m]  = pqlt[w];
          exp_bend[m] = pbend[w];
          exp_car[m]  = pcar[w];
          if (t_dead != 0) next_ok[m][w] = edge_n + t_dead + 1;
        end
      end
      for (int i = 0; i < NCH; i++) exp_lock[m][i] = (edge_n + 1 < next_ok[m][i]);
    end
    pv = t_vld;
    pbsy = t_bsy;
    for (int i = 0; i < NCH; i++) begin
      ppat[i] = t_pat[i]; pkey[i] = t_key[i]; poffs[i] = t_offs[i];
      pqlt[i] = t_qlt[i]; pbend[i] = t_bend[i]; pcar[i] = t_car[i];
    end
    #1;
  endtask

  function automatic logic [OUTW-1:0] exp_vec(int m);
    return {exp_vld[m], exp_bsy[m], CHW'(exp_ch[m]), PATW'(exp_pat[m]), (CHW+KEYW)'(exp_key[m]),
            (CHW+KEYW+2)'(exp_sub[m]), QLTW'(exp_qlt[m]), BNDW'(exp_bend[m]), CARW'(exp_car[m]),
            exp_lock[m]};
  endfunction

  function automatic logic [OUTW-1:0] dut_vec(int m);
    if (m == 0)
      return {if0.best_vld, if0.best_bsy, if0.best_ch, if0.best_pat, if0.best_key, if0.best_subkey,
              if0.best_qlt, if0.best_bend, if0.best_carry, if0.lock_mask};
    return {if1.best_vld, if1.best_bsy, if1.best_ch, if1.best_pat, if1.best_key, if1.best_subkey,
            if1.best_qlt, if1.best_bend, if1.best_carry, if1.lock_mask};
  endfunction

  task automatic test_reset();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (dut_vec(m) !== '0) begin
        n_fail++; $display("FAIL reset_outs dut%0d got=%h exp=0", m, dut_vec(m));
      end
    end
  endtask

  task automatic test_basic();
    int k3;
    t_dead = 0; rand_set();
    for (int i = 0; i < NCH; i++) t_pat[i] = 'h10;
    t_pat[3] = 'h7E; t_bsy = '0; t_vld = 1'b1; apply(); step();
    t_vld = 1'b0; apply(); step();
    k3 = 3 * 32 + t_key[3];
    n_checks++;
    if (if0.best_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld got=%0d exp=1", if0.best_vld); end
    n_checks++;
    if (if0.best_ch !== 4'd3) begin n_fail++; $display("FAIL basic_ch got=%0d exp=3", if0.best_ch); end
    n_checks++;
    if (if0.best_pat !== 7'h7E) begin n_fail++; $display("FAIL basic_pat got=%h exp=7e", if0.best_pat); end
    n_checks++;
    if (int'(if0.best_key) !== k3) begin n_fail++; $display("FAIL basic_key got=%0d exp=%0d", if0.best_key, k3); end
    n_checks++;
    if (int'(if0.best_subkey) !== t_offs[3] + 2 * k3) begin
      n_fail++; $display("FAIL basic_subkey got=%0d exp=%0d", if0.best_subkey, t_offs[3] + 2 * k3);
    end
    n_checks++;
    if (dut_vec(1) !== exp_vec(1)) begin n_fail++; $display("FAIL basic_lut got=%h exp=%h", dut_vec(1), exp_vec(1)); end
    step();
    n_checks++;
    if (if0.best_vld !== 1'b0) begin n_fail++; $display("FAIL basic_idle got=%0d exp=0", if0.best_vld); end
  endtask

  task automatic test_tie();
    t_dead = 0; rand_set();
    for (int i = 0; i < NCH; i++) t_pat[i] = $urandom_range(0, 'h7D);
    t_pat[1] = 'h7E; t_pat[5] = 'h7F;
    t_bsy = '0; t_vld = 1'b1; apply(); step();
    t_bsy[1] = 1'b1; apply(); step();
    n_checks++;
    if (if0.best_ch !== 4'd1) begin n_fail++; $display("FAIL tie_low got=%0d exp=1", if0.best_ch); end
    t_vld = 1'b0; apply(); step();
    n_checks++;
    if (if0.best_ch !== 4'd5) begin n_fail++; $display("FAIL tie_busy got=%0d exp=5", if0.best_ch); end
    n_checks++;
    if (dut_vec(0) !== exp_vec(0)) begin n_fail++; $display("FAIL tie_model got=%h exp=%h", dut_vec(0), exp_vec(0)); end
  endtask

  task automatic test_all_busy();
    logic [OUTW-1:0] want;
    want = {2'b11, {(OUTW-2){1'b0}}};
    rand_set(); t_bsy = '1; t_vld = 1'b1; apply(); step();
    t_vld = 1'b0; t_bsy = '0; apply(); step();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (dut_vec(m) !== want) begin n_fail++; $display("FAIL allbusy dut%0d got=%h exp=%h", m, dut_vec(m), want); end
    end
    step();
    n_checks++;
    if ({if0.best_vld, if0.best_bsy} !== 2'b00) begin
      n_fail++; $display("FAIL allbusy_idle got=%b exp=00", {if0.best_vld, if0.best_bsy});
    end
  endtask

  task automatic test_lockout();
    int seq[$];
    int lk;
    lk = 0;
    t_dead = 3; t_vld = 1'b0; apply(); step();
    rand_set();
    for (int i = 0; i < NCH; i++) t_pat[i] = $urandom_range(0, 'h7D);
    t_pat[2] = 'h7F; t_bsy = '0; t_vld = 1'b1; apply();
    for (int j = 0; j < 6; j++) begin
      step();
      n_checks++;
      if (dut_vec(0) !== exp_vec(0)) begin n_fail++; $display("FAIL lock_model j=%0d got=%h exp=%h", j, dut_vec(0), exp_vec(0)); end
      if (j >= 1 && if0.best_vld === 1'b1) seq.push_back(int'(if0.best_ch));
      if (j <= 4 && if0.lock_mask[2] === 1'b1) lk++;
    end
    t_vld = 1'b0; apply();
    n_checks++;
    if (seq.size() < 5) begin n_fail++; $display("FAIL lock_seq_len got=%0d exp=5", seq.size()); end
    else begin
      n_checks++;
      if (seq[0] != 2 || seq[4] != 2) begin n_fail++; $display("FAIL lock_seq_ends got=%0d,%0d exp=2,2", seq[0], seq[4]); end
      for (int k = 1; k <= 3; k++) begin
        n_checks++;
        if (seq[k] == 2) begin n_fail++; $display("FAIL lock_seq_mid k=%0d got=2 exp=not2", k); end
      end
    end
    n_checks++;
    if (lk != 3) begin n_fail++; $display("FAIL lock_mask_len got=%0d exp=3", lk); end
    t_dead = 0; apply();
    repeat (5) step();
  endtask

  task automatic test_patlut();
    rand_set();
    for (int i = 0; i < NCH; i++) begin
      t_offs[i] = 15; t_key[i] = 31; t_car[i] = 4095;
      t_qlt[i] = $urandom_range(0, 62); t_pat[i] = $urandom_range(2, 127);
    end
    t_qlt[6] = 63; t_pat[6] = 0;
    t_dead = 0; t_bsy = '0; t_vld = 1'b1; apply(); step();
    t_vld = 1'b0; apply(); step();
    n_checks++;
    if (if1.best_ch !== 4'd6) begin n_fail++; $display("FAIL lut_ch got=%0d exp=6", if1.best_ch); end
    n_checks++;
    if (if1.best_key !== 9'd223) begin n_fail++; $display("FAIL lut_key got=%0d exp=223", if1.best_key); end
    n_checks++;
    if (if1.best_subkey !== 11'd461) begin n_fail++; $display("FAIL lut_subkey got=%0d exp=461", if1.best_subkey); end
    n_checks++;
    if (if1.best_carry !== 12'hFFF) begin n_fail++; $display("FAIL lut_carry got=%h exp=fff", if1.best_carry); end
    n_checks++;
    if (if0.best_ch === 4'd6) begin n_fail++; $display("FAIL pat_sort_ch got=6 exp=not6"); end
    n_checks++;
    if (dut_vec(0) !== exp_vec(0)) begin n_fail++; $display("FAIL pat_sort_model got=%h exp=%h", dut_vec(0), exp_vec(0)); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rand_set();
      t_vld = ($urandom_range(0, 9) < 8);
      for (int i = 0; i < NCH; i++) t_bsy[i] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) t_bsy = '1;
      if ($urandom_range(0, 15) == 0) t_dead = $urandom_range(0, 5);
      apply(); step();
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (dut_vec(m) !== exp_vec(m)) begin
          n_fail++; $display("FAIL rand dut%0d n=%0d got=%h exp=%h", m, n, dut_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    t_dead = 7; t_bsy = '0; t_vld = 1'b1;
    for (int j = 0; j < 4; j++) begin rand_set(); apply(); step(); end
    n_checks++;
    if (if0.lock_mask !== exp_lock[0] || exp_lock[0] == '0) begin
      n_fail++; $display("FAIL rst_pre_lock got=%b exp=%b", if0.lock_mask, exp_lock[0]);
    end
    #2 reset = 1'b1;
    t_vld = 1'b0; apply();
    #1;
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (dut_vec(m) !== '0) begin n_fail++; $display("FAIL rst_async dut%0d got=%h exp=0", m, dut_vec(m)); end
    end
    #1 reset = 1'b0;
    model_reset();
    step();
    n_checks++;
    if (if0.best_vld !== 1'b0) begin n_fail++; $display("FAIL rst_idle got=%0d exp=0", if0.best_vld); end
    rand_set(); t_vld = 1'b1; apply(); step();
    n_checks++;
    if (if0.best_vld !== 1'b0) begin n_fail++; $display("FAIL rst_lat1 got=%0d exp=0", if0.best_vld); end
    t_vld = 1'b0; apply(); step();
    n_checks++;
    if (if0.best_vld !== 1'b1) begin n_fail++; $display("FAIL rst_lat2 got=%0d exp=1", if0.best_vld); end
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (dut_vec(m) !== exp_vec(m)) begin n_fail++; $display("FAIL rst_first dut%0d got=%h exp=%h", m, dut_vec(m), exp_vec(m)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    edge_n = 0;
    for (int i = 0; i < NCH; i++) begin
      t_pat[i] = 0; t_key[i] = 0; t_offs[i] = 0; t_qlt[i] = 0; t_bend[i] = 0; t_car[i] = 0;
    end
    t_bsy = '0; t_vld = 1'b0; t_dead = 0;
    apply();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b0;
    test_basic();
    test_tie();
    test_all_busy();
    test_lockout();
    test_patlut();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
